// File: rtl/data_bus_responder_if.sv
// Core-side data RAM port: access strobes, address, lane enables and both data directions.
interface data_bus_responder_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/data_bus_responder.sv
// Data-side responder: byte-laned RAM plus counter/timer/GPIO/TX-FIFO peripheral page.
// Reads are combinational (0 cycles); writes land on the edge. TX drain uses valid/ready.
module data_bus_responder #(
  parameter int RAM_DEPTH_LOG2 = 10,
  parameter int FIFO_LOG2      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_bus_responder_if.slave   bus,
  output logic [15:0]           gpio_o,
  output logic                  timer_irq_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i
);
  localparam int RAM_WORDS  = 1 << RAM_DEPTH_LOG2;
  localparam int FIFO_DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FIFO_FULL = (FIFO_LOG2 + 1)'(FIFO_DEPTH);

  logic [31:0] mem [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [31:0]          counter;
  logic [31:0]          timer_cmp;
  logic                 ovf;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2:0]   count;

  logic [RAM_DEPTH_LOG2-1:0] ram_idx;
  logic [2:0]                reg_off;
  logic ram_sel, per_sel, ram_wr, per_wr, rd_en;
  logic cmp_wr, gpio_wr, tx_wr, stat_wr;
  logic full, pop, push, drop, match;
  logic [31:0] status;
  logic        unused_addr_bits;

  assign ram_idx = bus.addr[RAM_DEPTH_LOG2+1:2];
  assign reg_off = bus.addr[4:2];
  assign ram_sel = bus.ce && (bus.addr[31:28] == 4'h0);
  assign per_sel = bus.ce && (bus.addr[31:28] == 4'h1);
  assign ram_wr  = ram_sel && bus.we;
  assign per_wr  = per_sel && bus.we;
  assign rd_en   = !rst && bus.ce && !bus.we;
  assign unused_addr_bits = ^{bus.addr[27:RAM_DEPTH_LOG2+2], bus.addr[1:0]};

  assign cmp_wr  = per_wr && (reg_off == 3'd1);
  assign gpio_wr = per_wr && (reg_off == 3'd2);
  assign tx_wr   = per_wr && (reg_off == 3'd3) && (bus.sel != 4'b0000);
  assign stat_wr = per_wr && (reg_off == 3'd4);

  assign full       = (count == FIFO_FULL);
  assign tx_valid_o = (count != '0);
  assign tx_data_o  = fifo_mem[rd_ptr];
  assign pop        = tx_valid_o && tx_ready_i;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign push       = tx_wr && (!full || pop);
  assign drop       = tx_wr && full && !pop;
  assign match      = (counter == timer_cmp) && (timer_cmp != '0);

  always_comb begin
    status = '0;
    status[0] = (count == '0);
    status[1] = full;
    status[2] = ovf;
    status[3] = timer_irq_o;
    status[4 +: FIFO_LOG2+1] = count;
  end

  always_comb begin
    bus.data_o = '0;
    if (rd_en && ram_sel) begin
      bus.data_o = mem[ram_idx];
    end else if (rd_en && per_sel) begin
      case (reg_off)
        3'd0:    bus.data_o = counter;
        3'd1:    bus.data_o = timer_cmp;
        3'd2:    bus.data_o = {16'h0000, gpio_o};
        3'd4:    bus.data_o = status;
        default: bus.data_o = '0;
      endcase
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.sel[l]) mem[ram_idx][8*l +: 8] <= bus.data_i[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= '0;
      timer_cmp   <= '0;
      gpio_o      <= '0;
      timer_irq_o <= 1'b0;
      ovf         <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (cmp_wr) begin
        timer_cmp   <= bus.data_i;
        timer_irq_o <= 1'b0;
      end else if (match) begin
        timer_irq_o <= 1'b1;
      end
      if (gpio_wr) gpio_o <= bus.data_i[15:0];
      if (drop) ovf <= 1'b1;
      else if (stat_wr && bus.data_i[2]) ovf <= 1'b0;
      if (push) begin
        fifo_mem[wr_ptr] <= bus.data_i[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule
